// File: rtl/rv_decode_scoreboard.sv
// RV32I decode stage: valid/ready on both sides, registered uop, busy-register scoreboard.
// One cycle from accept to out_valid; fetch is stalled by downstream backpressure or RAW/WAW hazards.
module rv_decode_scoreboard #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      inst_valid,
   input  logic [31:0]               instruction,
   output logic                      inst_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [6:0]                instruction_type,
   output logic [2:0]                funct3,
   output logic [6:0]                funct7,
   output logic [XLEN-1:0]           immediate,
   output logic [REG_ADDR_WIDTH-1:0] rs1,
   output logic [REG_ADDR_WIDTH-1:0] rs2,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      rs1_valid,
   output logic                      rs2_valid,
   output logic                      rd_valid,
   output logic                      illegal,
   input  logic                      wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [NUM_REGS-1:0]       busy_vec
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [6:0]                itype;
      logic [2:0]                f3;
      logic [6:0]                f7;
      logic [XLEN-1:0]           imm;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      rs1_v;
      logic                      rs2_v;
      logic                      rd_v;
      logic                      ill;
   } uop_t;

   uop_t                uop_q, uop_d, dec;
   logic                out_valid_q, out_valid_d;
   logic [NUM_REGS-1:0] busy_q, busy_d, set_vec, clr_vec;

   logic [6:0]                opcode, f7_raw;
   logic [2:0]                f3_raw;
   logic [REG_ADDR_WIDTH-1:0] rs1_raw, rs2_raw, rd_raw;
   logic [XLEN-1:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic                      legal, use_rs1, use_rs2, use_rd, use_f3, use_f7;
   logic                      hazard, accept;

   assign opcode  = instruction[6:0];
   assign f3_raw  = instruction[14:12];
   assign f7_raw  = instruction[31:25];
   assign rs1_raw = REG_ADDR_WIDTH'(instruction[19:15]);
   assign rs2_raw = REG_ADDR_WIDTH'(instruction[24:20]);
   assign rd_raw  = REG_ADDR_WIDTH'(instruction[11:7]);

   assign imm_i = XLEN'($signed(instruction[31:20]));
   assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
   assign imm_b = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                 instruction[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                 instruction[30:21], 1'b0}));

   always_comb begin
      dec     = '0;
      legal   = 1'b1;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      use_f3  = 1'b0;
      use_f7  = 1'b0;
      imm     = '0;
      case (opcode)
         OP_R: begin
            legal   = (f7_raw == 7'h00) || (f7_raw == 7'h20);
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            use_f3  = 1'b1;
            use_f7  = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            use_f3  = 1'b1;
            imm     = imm_i;
         end
         OP_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_f3  = 1'b1;
            imm     = imm_s;
         end
         OP_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_f3  = 1'b1;
            imm     = imm_b;
         end
         OP_LUI, OP_AUIPC: begin
            use_rd = 1'b1;
            imm    = imm_u;
         end
         OP_JAL: begin
            use_rd = 1'b1;
            imm    = imm_j;
         end
         OP_SYSTEM: begin
            // CSR ops read rs1 only for the register forms; the immediate forms reuse the field as uimm
            use_rd  = (f3_raw != 3'd0);
            use_rs1 = (f3_raw == 3'd1) || (f3_raw == 3'd2) || (f3_raw == 3'd3);
            use_f3  = 1'b1;
            imm     = imm_i;
         end
         default: legal = 1'b0;
      endcase

      if (legal) begin
         dec.itype = opcode;
         dec.f3    = use_f3  ? f3_raw  : '0;
         dec.f7    = use_f7  ? f7_raw  : '0;
         dec.imm   = imm;
         dec.rs1   = use_rs1 ? rs1_raw : '0;
         dec.rs2   = use_rs2 ? rs2_raw : '0;
         dec.rd    = use_rd  ? rd_raw  : '0;
         dec.rs1_v = use_rs1;
         dec.rs2_v = use_rs2;
         dec.rd_v  = use_rd && (rd_raw != '0);
      end else begin
         dec.ill = 1'b1;
      end
   end

   // No writeback bypass: a retiring register still blocks for the cycle it is written back.
   assign hazard = (dec.rs1_v & busy_q[dec.rs1]) |
                   (dec.rs2_v & busy_q[dec.rs2]) |
                   (dec.rd_v  & busy_q[dec.rd]);

   assign inst_ready = (~out_valid_q | out_ready) & ~hazard & ~flush & ~reset;
   assign accept     = inst_valid & inst_ready;

   always_comb begin
      uop_d       = uop_q;
      out_valid_d = out_valid_q;
      clr_vec     = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
      set_vec     = (accept && dec.rd_v) ? (NUM_REGS'(1) << dec.rd) : '0;
      set_vec[0]  = 1'b0;
      busy_d      = (busy_q & ~clr_vec) | set_vec;
      if (accept) begin
         uop_d       = dec;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (flush) begin
         out_valid_d = 1'b0;
         busy_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         uop_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         uop_q       <= uop_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign instruction_type = uop_q.itype;
   assign funct3           = uop_q.f3;
   assign funct7           = uop_q.f7;
   assign immediate        = uop_q.imm;
   assign rs1              = uop_q.rs1;
   assign rs2              = uop_q.rs2;
   assign rd               = uop_q.rd;
   assign rs1_valid        = uop_q.rs1_v;
   assign rs2_valid        = uop_q.rs2_v;
   assign rd_valid         = uop_q.rd_v;
   assign illegal          = uop_q.ill;
   assign busy_vec         = busy_q;

endmodule

// File: tb/tb_rv_decode_scoreboard.sv
// Bench for rv_decode_scoreboard: decode table plus hazard, backpressure, flush and reset sequences.
module tb_rv_decode_scoreboard;
   logic        clk, reset, flush, inst_valid, inst_ready, out_valid, out_ready;
   logic [31:0] instruction, immediate, busy_vec;
   logic [6:0]  instruction_type, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd, wb_rd;
   logic        rs1_valid, rs2_valid, rd_valid, illegal, wb_valid;

   rv_decode_scoreboard #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .inst_valid(inst_valid), .instruction(instruction), .inst_ready(inst_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction_type(instruction_type), .funct3(funct3), .funct7(funct7),
      .immediate(immediate), .rs1(rs1), .rs2(rs2), .rd(rd),
      .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid), .illegal(illegal),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .busy_vec(busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  typ;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rs1v, rs2v, rdv, ill;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [31:0] instr, input logic [6:0] typ, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] d, input logic v1,
                               input logic v2, input logic vd, input logic ill);
      vec_t v;
      v.instr = instr; v.typ = typ; v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.rs1 = r1; v.rs2 = r2; v.rd = d; v.rs1v = v1; v.rs2v = v2; v.rdv = vd; v.ill = ill;
      return v;
   endfunction

   // ADDI xd, x0, imm
   function automatic vec_t addi(input logic [4:0] d, input logic [11:0] im);
      logic [31:0] sx;
      sx = {{20{im[11]}}, im};
      return mk({im, 5'd0, 3'd0, d, 7'h13}, 7'h13, 3'd0, 7'h00, sx, 5'd0, 5'd0, d,
                1'b1, 1'b0, d != 5'd0, 1'b0);
   endfunction

   function automatic logic [67:0] pack(input vec_t v);
      return {v.typ, v.f3, v.f7, v.imm, v.rs1, v.rs2, v.rd, v.rs1v, v.rs2v, v.rdv, v.ill};
   endfunction

   function automatic logic [67:0] act_uop();
      return {instruction_type, funct3, funct7, immediate, rs1, rs2, rd,
              rs1_valid, rs2_valid, rd_valid, illegal};
   endfunction

   // funct fields of an illegal uop are not pinned down, so they are not compared
   function automatic logic [67:0] msk(input vec_t v);
      return v.ill ? {7'h7f, 3'h0, 7'h00, {51{1'b1}}} : {68{1'b1}};
   endfunction

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present v until accepted; returns 1ns after the accepting edge with inst_valid dropped.
   task automatic offer(input vec_t v);
      bit done;
      done = 1'b0;
      inst_valid  = 1'b1;
      instruction = v.instr;
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (inst_ready) begin
            exp_q.push_back(v);
            done = 1'b1;
         end
         tick();
         if (!done) #1;
      end
      inst_valid = 1'b0;
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout_%08h: got no accept, want accept within 40 cycles", v.instr);
      end
   endtask

   task automatic retire(input logic [4:0] r);
      wb_valid = 1'b1;
      wb_rd    = r;
      tick();
      wb_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_uop: got %h, want no uop", act_uop());
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            chk($sformatf("uop_%08h", e.instr), act_uop() & msk(e), pack(e) & msk(e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, want finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va, vb, vc;

      tbl.push_back(mk(32'hFFF00093, 7'h13, 3'd0, 7'h00, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  1, 0, 1, 0));
      tbl.push_back(mk(32'h00108133, 7'h33, 3'd0, 7'h00, 32'h00000000, 5'd1,  5'd1,  5'd2,  1, 1, 1, 0));
      tbl.push_back(mk(32'hFE000EE3, 7'h63, 3'd0, 7'h00, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0));
      tbl.push_back(mk(32'h0010006F, 7'h6F, 3'd0, 7'h00, 32'h00000800, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0));
      tbl.push_back(mk(32'h123452B7, 7'h37, 3'd0, 7'h00, 32'h12345000, 5'd0,  5'd0,  5'd5,  0, 0, 1, 0));
      tbl.push_back(mk(32'hFFFFF397, 7'h17, 3'd0, 7'h00, 32'hFFFFF000, 5'd0,  5'd0,  5'd7,  0, 0, 1, 0));
      tbl.push_back(mk(32'hFE612C23, 7'h23, 3'd2, 7'h00, 32'hFFFFFFF8, 5'd2,  5'd6,  5'd0,  1, 1, 0, 0));
      tbl.push_back(mk(32'h0101A403, 7'h03, 3'd2, 7'h00, 32'h00000010, 5'd3,  5'd0,  5'd8,  1, 0, 1, 0));
      tbl.push_back(mk(32'h80048567, 7'h67, 3'd0, 7'h00, 32'hFFFFF800, 5'd9,  5'd0,  5'd10, 1, 0, 1, 0));
      tbl.push_back(mk(32'h40D605B3, 7'h33, 3'd0, 7'h20, 32'h00000000, 5'd12, 5'd13, 5'd11, 1, 1, 1, 0));
      tbl.push_back(mk(32'h7FF8F813, 7'h13, 3'd7, 7'h00, 32'h000007FF, 5'd17, 5'd0,  5'd16, 1, 0, 1, 0));
      tbl.push_back(mk(32'h40008033, 7'h33, 3'd0, 7'h20, 32'h00000000, 5'd1,  5'd0,  5'd0,  1, 1, 0, 0));
      tbl.push_back(mk(32'h0000007F, 7'h00, 3'd0, 7'h00, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1));
      tbl.push_back(mk(32'h80008033, 7'h00, 3'd0, 7'h00, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1));
      tbl.push_back(mk(32'h00000073, 7'h73, 3'd0, 7'h00, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0));
      tbl.push_back(mk(32'h0007A773, 7'h73, 3'd2, 7'h00, 32'h00000000, 5'd15, 5'd0,  5'd14, 1, 0, 1, 0));
      tbl.push_back(mk(32'h0002D773, 7'h73, 3'd5, 7'h00, 32'h00000000, 5'd0,  5'd0,  5'd14, 0, 0, 1, 0));

      reset = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
      inst_valid = 1'b1; instruction = 32'hFFF00093; out_ready = 1'b1;
      tick();
      tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy_vec, 0);
      chk("reset_fields", act_uop(), 0);
      chk("reset_inst_ready", inst_ready, 0);
      reset = 1'b0; inst_valid = 1'b0; instruction = 32'h0;
      #1;
      chk("idle_inst_ready", inst_ready, 1);
      tick();

      foreach (tbl[i]) begin
         offer(tbl[i]);
         chk($sformatf("busy_set_%08h", tbl[i].instr), busy_vec,
             tbl[i].rdv ? (32'h1 << tbl[i].rd) : 32'h0);
         if (tbl[i].rdv) retire(tbl[i].rd);
         else tick();
         chk($sformatf("busy_clr_%08h", tbl[i].instr), busy_vec, 0);
      end

      // RAW stall on x1 released only the cycle after writeback
      va = tbl[0];
      vb = tbl[1];
      offer(va);
      chk("addi_out_valid", out_valid, 1);
      chk("addi_busy", busy_vec, 32'h2);
      inst_valid = 1'b1; instruction = vb.instr;
      #1;
      chk("raw_stall", inst_ready, 0);
      tick();
      chk("raw_stall_hold", inst_ready, 0);
      wb_valid = 1'b1; wb_rd = 5'd1;
      #1;
      chk("raw_no_bypass", inst_ready, 0);
      tick();
      wb_valid = 1'b0;
      #1;
      chk("raw_release", inst_ready, 1);
      chk("raw_busy_cleared", busy_vec, 0);
      exp_q.push_back(vb);
      tick();
      inst_valid = 1'b0;
      chk("add_busy", busy_vec, 32'h4);
      retire(5'd2);

      // Backpressure holds the uop bit-exact and blocks fetch
      va = addi(5'd9, 12'd5);
      vb = addi(5'd10, 12'd6);
      offer(va);
      out_ready = 1'b0; inst_valid = 1'b1; instruction = vb.instr;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_valid_%0d", k), out_valid, 1);
         chk($sformatf("bp_hold_%0d", k), act_uop(), pack(va));
         chk($sformatf("bp_ready_%0d", k), inst_ready, 0);
         tick();
         #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", inst_ready, 1);
      exp_q.push_back(vb);
      tick();
      inst_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_busy", busy_vec, 32'h0000_0600);
      retire(5'd9);
      retire(5'd10);

      // Set beats a same-cycle clear of the same register
      va = addi(5'd3, 12'd1);
      inst_valid = 1'b1; instruction = va.instr; wb_valid = 1'b1; wb_rd = 5'd3;
      #1;
      chk("simul_ready", inst_ready, 1);
      exp_q.push_back(va);
      tick();
      inst_valid = 1'b0; wb_valid = 1'b0;
      chk("simul_busy", busy_vec, 32'h8);
      retire(5'd3);

      // Flush during a hazard stall clears the scoreboard; stalled op goes next cycle
      va = addi(5'd5, 12'd1);
      vb = mk(32'h00528333, 7'h33, 3'd0, 7'h00, 32'h0, 5'd5, 5'd5, 5'd6, 1, 1, 1, 0);
      offer(va);
      chk("flush_pre_busy", busy_vec, 32'h20);
      inst_valid = 1'b1; instruction = vb.instr;
      #1;
      chk("flush_pre_stall", inst_ready, 0);
      tick();
      flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd9;
      #1;
      chk("flush_ready", inst_ready, 0);
      tick();
      flush = 1'b0; wb_valid = 1'b0;
      chk("flush_busy", busy_vec, 0);
      chk("flush_out_valid", out_valid, 0);
      #1;
      chk("flush_release", inst_ready, 1);
      exp_q.push_back(vb);
      tick();
      inst_valid = 1'b0;
      chk("flush_after_valid", out_valid, 1);
      chk("flush_after_busy", busy_vec, 32'h40);
      retire(5'd6);

      // Flush squashes a held uop
      out_ready = 1'b0;
      offer(addi(5'd7, 12'd2));
      chk("squash_pre_valid", out_valid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("squash_valid", out_valid, 0);
      chk("squash_busy", busy_vec, 0);
      void'(exp_q.pop_back());
      out_ready = 1'b1;

      // Back-to-back independent uops, one per cycle
      for (int n = 20; n < 24; n++) begin
         vc = addi(5'(n), 12'(n));
         inst_valid = 1'b1; instruction = vc.instr;
         #1;
         chk($sformatf("burst_ready_%0d", n), inst_ready, 1);
         exp_q.push_back(vc);
         tick();
      end
      inst_valid = 1'b0;
      chk("burst_busy", busy_vec, 32'h00F0_0000);
      for (int n = 20; n < 24; n++) retire(5'(n));
      chk("burst_busy_clr", busy_vec, 0);

      // Reset beats flush and writeback, and clears the uop fields
      out_ready = 1'b0;
      offer(addi(5'd8, 12'd3));
      reset = 1'b1; flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd8;
      tick();
      reset = 1'b0; flush = 1'b0; wb_valid = 1'b0;
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_busy", busy_vec, 0);
      chk("rst2_fields", act_uop(), 0);
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
